// File: rtl/x_muldiv_unit.sv
// x_muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
//
// Sits in the execute stage behind the DX forwarding mux. A MULT/MULTU/DIV/DIVU
// op takes WIDTH iterations (one per cycle) plus a single sign-fix cycle. MTHI
// and MTLO write HI/LO directly in one cycle without raising busy.
//
// Ports:
//   clk     pipeline clock
//   rst     synchronous, active-high reset
//   start   valid mul/div op presented this cycle
//   op      0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   rs_val  forwarded rs operand (multiplicand / dividend / MTHI-MTLO data)
//   rt_val  forwarded rt operand (multiplier / divisor)
//   flush   abort any in-flight op; beats a same-cycle start
//   busy    op in flight (registered state decode)
//   done    one-cycle pulse after HI/LO take a new mul/div result
//   hi, lo  HI/LO registers
module x_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   // Shared accumulator: product for multiply, {remainder, quotient} for divide.
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   // Second operand magnitude: multiplicand addend or divisor.
   logic [WIDTH-1:0]     opb_q, opb_d;
   // Raw rs kept for the divide-by-zero HI result.
   logic [WIDTH-1:0]     raw_rs_q, raw_rs_d;
   logic                 is_div_q, is_div_d;
   logic                 div_zero_q, div_zero_d;
   // Operand signs; always zero for unsigned ops so the fix-up is a no-op.
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   // Start-time operand conditioning.
   logic                 op_signed, op_div, op_arith;
   logic                 rs_neg, rt_neg;
   logic [WIDTH-1:0]     rs_abs, rt_abs;

   assign op_signed = (op == OpMult) || (op == OpDiv);
   assign op_div    = (op == OpDiv) || (op == OpDivu);
   assign op_arith  = (op == OpMult) || (op == OpMultu) || op_div;
   assign rs_neg    = op_signed & rs_val[WIDTH-1];
   assign rt_neg    = op_signed & rt_val[WIDTH-1];
   // The most negative value maps onto itself, which is the correct unsigned magnitude.
   assign rs_abs    = rs_neg ? -rs_val : rs_val;
   assign rt_abs    = rt_neg ? -rt_val : rt_val;

   // Radix-2 shift-add step: add the multiplicand into the upper half when the
   // current multiplier bit (acc LSB) is set, then shift the whole thing right.
   logic [WIDTH-1:0]     mul_addend;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;

   assign mul_addend = acc_q[0] ? opb_q : '0;
   assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
   assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

   // Restoring divide step: shift the next dividend bit into the partial
   // remainder, try the subtraction, keep it only if it did not borrow.
   logic [WIDTH:0]       rem_shift;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   div_next;

   assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff  = rem_shift - {1'b0, opb_q};
   assign div_next  = div_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   // Sign fix-up applied in StFix.
   logic                 neg_result;
   logic [2*WIDTH-1:0]   prod_fixed;
   logic [WIDTH-1:0]     quot_raw, rem_raw;
   logic [WIDTH-1:0]     quot_fixed, rem_fixed;

   assign neg_result = sign_a_q ^ sign_b_q;
   assign prod_fixed = neg_result ? -acc_q : acc_q;
   assign quot_raw   = acc_q[WIDTH-1:0];
   assign rem_raw    = acc_q[2*WIDTH-1:WIDTH];
   assign quot_fixed = neg_result ? -quot_raw : quot_raw;
   assign rem_fixed  = sign_a_q ? -rem_raw : rem_raw;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      raw_rs_d   = raw_rs_q;
      is_div_d   = is_div_q;
      div_zero_d = div_zero_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               if (op_arith) begin
                  acc_d      = {{WIDTH{1'b0}}, rs_abs};
                  opb_d      = rt_abs;
                  raw_rs_d   = rs_val;
                  is_div_d   = op_div;
                  div_zero_d = (rt_val == '0);
                  sign_a_d   = rs_neg;
                  sign_b_d   = rt_neg;
                  cnt_d      = '0;
                  state_d    = StCalc;
               end else if (op == OpMthi) begin
                  hi_d = rs_val;
               end else if (op == OpMtlo) begin
                  lo_d = rs_val;
               end
            end
         end

         StCalc: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               state_d = StFix;
            end
         end

         StFix: begin
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fixed;
            end else if (div_zero_q) begin
               hi_d = raw_rs_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fixed;
               lo_d = quot_fixed;
            end
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Squash overrides everything above, including a same-cycle MTHI/MTLO.
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         raw_rs_q   <= '0;
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         raw_rs_q   <= raw_rs_d;
         is_div_q   <= is_div_d;
         div_zero_q <= div_zero_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
